masked_priority_interrupt_unit: RTL and testbench
=================================================

# masked_priority_interrupt_unit

Maskable, hardware-vectored, 4-source priority interrupt unit for the accumulator-based processor. It captures interrupt request and mask vectors into registers and gates the requests with the mask. It selects the highest-priority surviving request and drives the 8-bit ISR address for the PC load path, plus a pending flag to the control unit. It is built from three leaf blocks, each with the behaviour defined below: a 4-bit load/store register (two instances), a 4-to-2 priority encoder and a 4:1 8-bit mux.

## Interface
Parameters:
- None. ISR vector addresses are fixed constants (see Operation).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  reset, asynchronous, active-low; clears the interrupt and mask registers.
- itr_en  input  1  interrupt enable; load strobe for both registers and gate on i_pending.
- itr_in  input  4  raw interrupt request vector, bit n = source n.
- mask_in  input  4  mask vector; 1 = source enabled, 0 = masked.
- i_pending  output  1  an unmasked interrupt is pending and the handler is enabled.
- PC_out  output  8  ISR address of the selected interrupt.
- ITR_register  output  4  current interrupt register contents.
- MASK_register  output  4  current mask register contents.

## Operation
- Load/store register (4-bit, one each for ITR and MASK):
  - clr=0 forces the register to 4'b0000 immediately, independent of clk.
  - Otherwise, at a rising clk with set (itr_en)=1, the register loads its input.
  - With set=0 it holds its value.
  - Requests are not sticky: each enabled clock overwrites the register with the current itr_in/mask_in.
- Masking: active[n] = ITR_register[n] & MASK_register[n].
- Priority encoder (4→2, with enable and valid):
  - valid = enab & |in.
  - out = index of the highest-numbered set bit; bit 3 has highest priority, bit 0 lowest.
  - out = 2'b00 when no bit is set or enab=0.
  - The enable is tied high in this unit.
- i_pending = valid & itr_en.
- Vector mux (4:1, 8-bit, combinational) on encoder out:
  - 0 → 8'h96
  - 1 → 8'hB4 (overflow ISR)
  - 2 → 8'hD7
  - 3 → 8'h56 (zero-result ISR)
- PC_out is always driven; with nothing pending it shows 8'h96 and i_pending=0. Consumers must qualify PC_out with i_pending.
- ITR_register and MASK_register are direct register outputs.

## Timing
- Reset values: ITR_register=0, MASK_register=0, i_pending=0, PC_out=8'h96.
- clr low mid-operation clears both registers asynchronously. i_pending drops and PC_out returns to 8'h96 in the same delta, with no clock needed.
- Latency from itr_in/mask_in to i_pending/PC_out is 1 clock: sampled at the first rising edge with itr_en=1, outputs valid combinationally after that edge.
- itr_en falling forces i_pending=0 combinationally in the same cycle. The registers freeze, and PC_out keeps reflecting the frozen registers.
- itr_en rising re-asserts i_pending combinationally if the held registers already contain an unmasked request.
- Simultaneous requests: only the highest index wins. A lower request is presented once higher ones are cleared and reloaded.
- A fully masked request (mask bit 0) never asserts i_pending and never influences PC_out.
- clr and itr_en both active: clr wins, registers stay 0.

## Test plan
- Reset: clr=0 with itr_in=4'hF, mask_in=4'hF, itr_en=1 → registers 0, i_pending=0, PC_out=8'h96. Release clr, clock once → i_pending=1, PC_out=8'h56.
- Single source per bit (mask=4'hF, itr_en=1): itr_in=0001/0010/0100/1000 over successive clocks → PC_out=96/B4/D7/56 respectively, each with i_pending=1.
- Priority: itr_in=4'b0110, mask=4'hF → PC_out=8'hD7. Then mask=4'b1011 → PC_out=8'hB4.
- Masking: itr_in=4'b1000, mask=4'b0111 → i_pending=0, PC_out=8'h96.
- Enable gating: load itr_in=4'b0010 with mask=4'hF, then itr_en=0 and change itr_in to 0 → i_pending=0 immediately, ITR_register stays 4'b0010, PC_out=8'hB4. Re-assert itr_en → i_pending=1, then the next edge loads 0 and drops it.
- Async clear mid-operation: pending on bit 3, pulse clr low between clock edges → i_pending and ITR_register go to 0 without a clock edge.

Source files
------------

// File: rtl/masked_priority_interrupt_unit_if.sv
// Interrupt unit bus: request/mask/enable inputs plus pending flag, ISR vector
// and register observation outputs.
//   itr_en        - load strobe for both registers; also gates i_pending
//   itr_in        - raw request vector, bit n = source n
//   mask_in       - mask vector, 1 = source enabled
//   i_pending     - unmasked request present and handler enabled
//   PC_out        - ISR address of the selected source
//   ITR_register  - interrupt register contents
//   MASK_register - mask register contents
interface masked_priority_interrupt_unit_if;
  logic       itr_en;
  logic [3:0] itr_in;
  logic [3:0] mask_in;
  logic       i_pending;
  logic [7:0] PC_out;
  logic [3:0] ITR_register;
  logic [3:0] MASK_register;

  // Driver side (processor core / bench)
  modport master (
    output itr_en, itr_in, mask_in,
    input  i_pending, PC_out, ITR_register, MASK_register
  );

  // Interrupt unit side
  modport slave (
    input  itr_en, itr_in, mask_in,
    output i_pending, PC_out, ITR_register, MASK_register
  );
endinterface

// File: rtl/masked_priority_interrupt_unit.sv
// Maskable, hardware-vectored 4-source priority interrupt unit.
// Captures request and mask vectors, gates requests with the mask, selects the
// highest-numbered surviving source and drives its fixed ISR address.
//   clk - rising-edge clock
//   clr - asynchronous active-low clear of both registers
//   bus - interrupt unit interface (slave side)
module masked_priority_interrupt_unit (
  input  logic                           clk,
  input  logic                           clr,
  masked_priority_interrupt_unit_if.slave bus
);

  localparam int unsigned SRC_W = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned VEC_W = 8;

  localparam logic [VEC_W-1:0] VEC_SRC0 = 8'h96;
  localparam logic [VEC_W-1:0] VEC_SRC1 = 8'hB4; // overflow ISR
  localparam logic [VEC_W-1:0] VEC_SRC2 = 8'hD7;
  localparam logic [VEC_W-1:0] VEC_SRC3 = 8'h56; // zero-result ISR

  logic [SRC_W-1:0] itr_q;
  logic [SRC_W-1:0] mask_q;
  logic [SRC_W-1:0] active;
  logic [IDX_W-1:0] sel;
  logic             valid;
  logic             enab;
  logic [VEC_W-1:0] vector;

  // Encoder enable is permanently asserted in this unit
  assign enab = 1'b1;

  // Interrupt request register: non-sticky, overwritten on every enabled edge
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      itr_q <= '0;
    end else if (bus.itr_en) begin
      itr_q <= bus.itr_in;
    end
  end

  // Mask register, shares the load strobe with the request register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      mask_q <= '0;
    end else if (bus.itr_en) begin
      mask_q <= bus.mask_in;
    end
  end

  assign active = itr_q & mask_q;

  // Priority encoder: highest-numbered active source wins, 0 when idle
  always_comb begin
    sel   = '0;
    valid = enab & (|active);
    if (enab) begin
      if (active[3])      sel = IDX_W'(3);
      else if (active[2]) sel = IDX_W'(2);
      else if (active[1]) sel = IDX_W'(1);
      else                sel = IDX_W'(0);
    end
  end

  // ISR vector mux; idle selection falls through to the source-0 vector
  always_comb begin
    vector = VEC_SRC0;
    case (sel)
      2'd0:    vector = VEC_SRC0;
      2'd1:    vector = VEC_SRC1;
      2'd2:    vector = VEC_SRC2;
      2'd3:    vector = VEC_SRC3;
      default: vector = VEC_SRC0;
    endcase
  end

  // Pending is combinational so a falling itr_en masks it in the same cycle
  assign bus.i_pending     = valid & bus.itr_en;
  assign bus.PC_out        = vector;
  assign bus.ITR_register  = itr_q;
  assign bus.MASK_register = mask_q;

endmodule

// File: tb/tb_masked_priority_interrupt_unit.sv
// Directed + random bench for masked_priority_interrupt_unit with a queue
// scoreboard fed by a behavioural reference model.
module tb_masked_priority_interrupt_unit;

  typedef struct packed {
    logic       pend;
    logic [7:0] pc;
    logic [3:0] itr;
    logic [3:0] mask;
  } exp_t;

  logic clk;
  logic clr;
  int   vectors;
  int   miscompares;
  exp_t sb_q[$];

  // Reference model register state
  logic [3:0] m_itr;
  logic [3:0] m_mask;

  masked_priority_interrupt_unit_if bus ();

  masked_priority_interrupt_unit dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_vector(input logic [3:0] act);
    logic [7:0] tbl [4];
    logic [7:0] v;
    tbl[0] = 8'h96; tbl[1] = 8'hB4; tbl[2] = 8'hD7; tbl[3] = 8'h56;
    v = 8'h96;
    for (int n = 0; n < 4; n++) begin
      if (act[n]) v = tbl[n];
    end
    return v;
  endfunction

  // Predict from model state and live inputs, queue it, then compare the DUT
  task automatic check(input string tag);
    exp_t e;
    logic [3:0] act;
    act    = m_itr & m_mask;
    e.pend = bus.itr_en & (|act);
    e.pc   = ref_vector(act);
    e.itr  = m_itr;
    e.mask = m_mask;
    sb_q.push_back(e);

    e = sb_q.pop_front();
    vectors++;
    assert (bus.i_pending === e.pend) else begin
      miscompares++;
      $error("FAIL %s.pend observed=%b expected=%b", tag, bus.i_pending, e.pend);
    end
    vectors++;
    assert (bus.PC_out === e.pc) else begin
      miscompares++;
      $error("FAIL %s.pc observed=%h expected=%h", tag, bus.PC_out, e.pc);
    end
    vectors++;
    assert (bus.ITR_register === e.itr) else begin
      miscompares++;
      $error("FAIL %s.itr observed=%b expected=%b", tag, bus.ITR_register, e.itr);
    end
    vectors++;
    assert (bus.MASK_register === e.mask) else begin
      miscompares++;
      $error("FAIL %s.mask observed=%b expected=%b", tag, bus.MASK_register, e.mask);
    end
  endtask

  // One rising edge, model updated as the registers would be, then settle
  task automatic tick();
    @(posedge clk);
    if (clr && bus.itr_en) begin
      m_itr  = bus.itr_in;
      m_mask = bus.mask_in;
    end
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_itr       = 4'h0;
    m_mask      = 4'h0;

    // Reset held with everything else active
    clr         = 1'b0;
    bus.itr_en  = 1'b1;
    bus.itr_in  = 4'hF;
    bus.mask_in = 4'hF;
    #1;
    check("reset");
    tick();
    check("reset_clk");

    clr = 1'b1;
    tick();
    check("release");

    // One source at a time
    for (int i = 0; i < 4; i++) begin
      bus.itr_in = 4'(1 << i);
      tick();
      check($sformatf("single%0d", i));
    end

    // Priority between two requests, then mask out the winner
    bus.itr_in = 4'b0110; bus.mask_in = 4'hF;
    tick();
    check("prio_both");
    bus.mask_in = 4'b1011;
    tick();
    check("prio_masked");

    // Fully masked request
    bus.itr_in = 4'b1000; bus.mask_in = 4'b0111;
    tick();
    check("masked");

    // Enable gating and freeze
    bus.itr_in = 4'b0010; bus.mask_in = 4'hF;
    tick();
    check("gate_load");
    bus.itr_en = 1'b0;
    bus.itr_in = 4'b0000;
    #1;
    check("gate_off");
    tick();
    check("gate_hold");
    bus.itr_en = 1'b1;
    #1;
    check("gate_on");
    tick();
    check("gate_reload");

    // Asynchronous clear between edges
    bus.itr_in = 4'b1000;
    tick();
    check("clr_pre");
    #2;
    clr    = 1'b0;
    m_itr  = 4'h0;
    m_mask = 4'h0;
    #1;
    check("clr_async");
    #1;
    clr = 1'b1;
    tick();
    check("clr_post");

    // Random traffic
    for (int k = 0; k < 24; k++) begin
      bus.itr_en  = 1'($urandom_range(0, 3) != 0);
      bus.itr_in  = 4'($urandom_range(0, 15));
      bus.mask_in = 4'($urandom_range(0, 15));
      tick();
      check($sformatf("rand%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
